// File: rtl/cpu_defs.sv
// Shared constants for the fetch stage: next-PC select encodings, exception
// codes and the instruction-memory address window.
package cpu_defs;
  localparam logic [1:0]  NPC_PC4    = 2'd0;
  localparam logic [1:0]  NPC_BR     = 2'd1;
  localparam logic [1:0]  NPC_J      = 2'd2;
  localparam logic [1:0]  NPC_JR     = 2'd3;

  localparam logic [3:0]  EXC_NONE   = 4'd0;
  localparam logic [3:0]  EXC_ADEL   = 4'd4;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;
endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target generator: sequential, branch, j/jal and jr/jalr
// targets selected by the D-stage decision.
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  output logic [31:0] pc_add4,
  output logic [31:0] npc
);
  logic [31:0] d_pc_add4;
  logic [31:0] br_off;

  assign pc_add4   = pc + 32'd4;
  assign d_pc_add4 = d_pc + 32'd4;
  assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};

  // Targets are relative to the instruction in D; the delay slot is already fetched.
  always_comb begin
    npc = pc_add4;
    case (npc_sel)
      NPC_PC4: npc = pc_add4;
      NPC_BR:  npc = d_pc_add4 + br_off;
      NPC_J:   npc = {d_pc_add4[31:28], index26, 2'b00};
      NPC_JR:  npc = rs_val;
      default: npc = pc_add4;
    endcase
  end
endmodule

// File: rtl/if_fetch_pc.sv
// IF stage: PC register with exception/eret/stall priority, AdEL detection on
// the fetch address, and delay-slot flag generation for IF/ID.
module if_fetch_pc
  import cpu_defs::*;
#(
  parameter logic [31:0] P_RESET_PC   = RESET_PC,
  parameter logic [31:0] P_HANDLER_PC = HANDLER_PC,
  parameter logic [31:0] P_IM_LO      = IM_LO,
  parameter logic [31:0] P_IM_HI      = IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  input  logic        d_is_bj,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_add4,
  output logic [31:0] instr,
  output logic [3:0]  exc_code,
  output logic        bd
);
  logic [31:0] npc;
  logic        adel;
  logic        first_q;
  logic        ret_q;
  logic        bd_hold_q;

  npc_calc u_npc_calc (
    .pc      (pc),
    .npc_sel (npc_sel),
    .d_pc    (d_pc),
    .imm16   (imm16),
    .index26 (index26),
    .rs_val  (rs_val),
    .pc_add4 (pc_add4),
    .npc     (npc)
  );

  // first_q marks the first fetch after reset/req; ret_q marks the eret return fetch.
  // Both persist across stalls since the same fetch is being repeated.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= P_RESET_PC;
      first_q <= 1'b1;
      ret_q   <= 1'b0;
    end else if (req) begin
      pc      <= P_HANDLER_PC;
      first_q <= 1'b1;
      ret_q   <= 1'b0;
    end else if (eret && !stall) begin
      pc      <= epc;
      first_q <= 1'b0;
      ret_q   <= 1'b1;
    end else if (!stall) begin
      pc      <= npc;
      first_q <= 1'b0;
      ret_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bd_hold_q <= 1'b0;
    else       bd_hold_q <= bd;
  end

  assign adel     = (pc[1:0] != 2'b00) || (pc < P_IM_LO) || (pc > P_IM_HI);
  assign im_addr  = pc;
  assign instr    = adel ? 32'd0 : im_rdata;
  assign exc_code = adel ? EXC_ADEL : EXC_NONE;
  assign bd       = first_q ? 1'b0 : (ret_q ? bd_hold_q : d_is_bj);
endmodule

// File: tb/tb_if_fetch_pc.sv
// Self-checking bench for if_fetch_pc: directed vector table followed by
// randomized traffic against a behavioural fetch model.
module tb_if_fetch_pc;
  logic        clk = 1'b0;
  logic        reset, req, eret, stall, d_is_bj;
  logic [31:0] epc, d_pc, rs_val, im_rdata;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] im_addr, pc, pc_add4, instr;
  logic [3:0]  exc_code;
  logic        bd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_pc dut (
    .clk(clk), .reset(reset), .req(req), .eret(eret), .epc(epc), .stall(stall),
    .npc_sel(npc_sel), .d_pc(d_pc), .imm16(imm16), .index26(index26),
    .rs_val(rs_val), .d_is_bj(d_is_bj), .im_rdata(im_rdata),
    .im_addr(im_addr), .pc(pc), .pc_add4(pc_add4), .instr(instr),
    .exc_code(exc_code), .bd(bd)
  );

  typedef struct {
    logic        rst, rq, er, st, bj;
    logic [1:0]  sel;
    logic [31:0] dpc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs, ep, imr;
    logic [31:0] e_pc;
    logic [3:0]  e_exc;
    logic        e_bd;
  } vec_t;

  localparam int NV = 23;
  vec_t v[NV];

  function automatic vec_t mk(logic rst, logic rq, logic er, logic st, logic [1:0] sel,
                              logic [31:0] dpc, logic [15:0] imm, logic [25:0] idx,
                              logic [31:0] rs, logic [31:0] ep, logic bj, logic [31:0] imr,
                              logic [31:0] e_pc, logic [3:0] e_exc, logic e_bd);
    vec_t r;
    r.rst = rst; r.rq = rq; r.er = er; r.st = st; r.sel = sel; r.dpc = dpc;
    r.imm = imm; r.idx = idx; r.rs = rs; r.ep = ep; r.bj = bj; r.imr = imr;
    r.e_pc = e_pc; r.e_exc = e_exc; r.e_bd = e_bd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [3:0] e_exc,
                           input logic e_bd, input logic [31:0] imr);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " im_addr"}, im_addr, e_pc);
    chk({tag, " pc_add4"}, pc_add4, e_pc + 32'd4);
    chk({tag, " exc_code"}, {28'd0, exc_code}, {28'd0, e_exc});
    chk({tag, " instr"}, instr, (e_exc == 4'd4) ? 32'd0 : imr);
    chk({tag, " bd"}, {31'd0, bd}, {31'd0, e_bd});
  endtask

  // Behavioural model state
  logic [31:0] m_pc;
  int          m_phase;   // 0 normal, 1 first fetch after reset/req, 2 eret return
  logic        m_bd_prev;

  function automatic logic m_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  function automatic logic m_bd(input int phase, input logic prev, input logic bj);
    if (phase == 1) return 1'b0;
    if (phase == 2) return prev;
    return bj;
  endfunction

  localparam logic [31:0] IMR = 32'h1234_5678;

  initial begin
    reset = 1'b1; req = 0; eret = 0; stall = 0; d_is_bj = 0; epc = 0; d_pc = 0;
    rs_val = 0; im_rdata = IMR; npc_sel = 0; imm16 = 0; index26 = 0;

    //            rst rq er st sel dpc           imm       idx        rs            epc           bj imr            e_pc          exc  bd
    v[0]  = mk(1, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        0, IMR,           32'h3000, 4'd0, 0);
    v[1]  = mk(1, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        1, IMR,           32'h3000, 4'd0, 0);
    v[2]  = mk(0, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        0, IMR,           32'h3004, 4'd0, 0);
    v[3]  = mk(0, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        0, IMR,           32'h3008, 4'd0, 0);
    v[4]  = mk(0, 0, 0, 0, 2'd1, 32'h3010,   16'hFFFE, 26'h0,     32'h0,        32'h0,        0, IMR,           32'h300C, 4'd0, 0);
    v[5]  = mk(0, 0, 0, 0, 2'd1, 32'h3010,   16'h0003, 26'h0,     32'h0,        32'h0,        0, IMR,           32'h3020, 4'd0, 0);
    v[6]  = mk(0, 0, 0, 0, 2'd3, 32'h0,      16'h0,    26'h0,     32'h3002,     32'h0,        0, IMR,           32'h3002, 4'd4, 0);
    v[7]  = mk(0, 0, 0, 0, 2'd3, 32'h0,      16'h0,    26'h0,     32'h7000,     32'h0,        0, IMR,           32'h7000, 4'd4, 0);
    v[8]  = mk(0, 0, 0, 0, 2'd3, 32'h0,      16'h0,    26'h0,     32'h3100,     32'h0,        0, IMR,           32'h3100, 4'd0, 0);
    v[9]  = mk(0, 0, 0, 1, 2'd2, 32'h0,      16'h0,    26'h123,   32'h0,        32'h0,        0, IMR,           32'h3100, 4'd0, 0);
    v[10] = mk(0, 0, 0, 1, 2'd2, 32'h0,      16'h0,    26'h123,   32'h0,        32'h0,        0, IMR,           32'h3100, 4'd0, 0);
    v[11] = mk(0, 0, 0, 1, 2'd2, 32'h0,      16'h0,    26'h123,   32'h0,        32'h0,        0, IMR,           32'h3100, 4'd0, 0);
    v[12] = mk(0, 1, 0, 1, 2'd2, 32'h0,      16'h0,    26'h123,   32'h0,        32'h0,        1, IMR,           32'h4180, 4'd0, 0);
    v[13] = mk(0, 0, 1, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h3040,     0, IMR,           32'h3040, 4'd0, 0);
    v[14] = mk(0, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        0, IMR,           32'h3044, 4'd0, 0);
    v[15] = mk(0, 0, 1, 1, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h3040,     0, IMR,           32'h3044, 4'd0, 0);
    v[16] = mk(0, 0, 1, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h3040,     0, IMR,           32'h3040, 4'd0, 0);
    v[17] = mk(0, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        1, 32'h2409_0001, 32'h3044, 4'd0, 1);
    v[18] = mk(0, 0, 0, 0, 2'd2, 32'h3044,   16'h0,    26'h0C10,  32'h0,        32'h0,        0, IMR,           32'h3040, 4'd0, 0);
    v[19] = mk(1, 1, 1, 1, 2'd3, 32'h0,      16'h0,    26'h0,     32'h5000,     32'h5000,     1, IMR,           32'h3000, 4'd0, 0);
    v[20] = mk(0, 0, 0, 0, 2'd3, 32'h0,      16'h0,    26'h0,     32'h6FFC,     32'h0,        0, IMR,           32'h6FFC, 4'd0, 0);
    v[21] = mk(0, 0, 0, 0, 2'd0, 32'h0,      16'h0,    26'h0,     32'h0,        32'h0,        0, IMR,           32'h7000, 4'd4, 0);
    v[22] = mk(0, 0, 0, 0, 2'd3, 32'h0,      16'h0,    26'h0,     32'h2FFC,     32'h0,        0, IMR,           32'h2FFC, 4'd4, 0);

    for (int i = 0; i < NV; i++) begin
      reset = v[i].rst; req = v[i].rq; eret = v[i].er; stall = v[i].st;
      npc_sel = v[i].sel; d_pc = v[i].dpc; imm16 = v[i].imm; index26 = v[i].idx;
      rs_val = v[i].rs; epc = v[i].ep; d_is_bj = v[i].bj; im_rdata = v[i].imr;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), v[i].e_pc, v[i].e_exc, v[i].e_bd, v[i].imr);
    end

    // Wrap-around: branch from the top of the address space, 32-bit modulo.
    npc_sel = 2'd1; d_pc = 32'hFFFF_FFF8; imm16 = 16'h0001; d_is_bj = 0;
    @(posedge clk); #1;
    check_all("wrap_br", 32'h0000_0000, 4'd4, 1'b0, IMR);

    // Randomized section: start from a known reset and follow the model.
    reset = 1; req = 0; eret = 0; stall = 0; npc_sel = 0;
    @(posedge clk); #1;
    m_pc = 32'h3000; m_phase = 1; m_bd_prev = 1'b0;
    check_all("rnd_reset", m_pc, 4'd0, 1'b0, im_rdata);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] nxt, tgt;
      int          nph;
      logic        cur_bd;
      reset    = ($urandom_range(0, 39) == 0);
      req      = ($urandom_range(0, 19) == 0);
      eret     = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      d_is_bj  = $urandom_range(0, 1) == 1;
      npc_sel  = 2'($urandom_range(0, 3));
      d_pc     = 32'h3000 + 32'($urandom_range(0, 32'h4000));
      imm16    = 16'($urandom);
      index26  = 26'($urandom_range(32'hBF0, 32'h1C08));
      rs_val   = 32'h2FF0 + 32'($urandom_range(0, 32'h4020));
      epc      = 32'h3000 + 4 * 32'($urandom_range(0, 32'hFFF));
      im_rdata = $urandom;

      case (npc_sel)
        2'd0:    tgt = m_pc + 4;
        2'd1:    tgt = d_pc + 4 + 32'($signed(imm16)) * 4;
        2'd2:    tgt = ((d_pc + 4) & 32'hF000_0000) | (32'(index26) * 4);
        default: tgt = rs_val;
      endcase
      cur_bd = m_bd(m_phase, m_bd_prev, d_is_bj);
      if (reset)      begin nxt = 32'h3000; nph = 1; end
      else if (req)   begin nxt = 32'h4180; nph = 1; end
      else if (stall) begin nxt = m_pc;     nph = m_phase; end
      else if (eret)  begin nxt = epc;      nph = 2; end
      else            begin nxt = tgt;      nph = 0; end

      @(posedge clk); #1;
      m_bd_prev = reset ? 1'b0 : cur_bd;
      m_pc = nxt; m_phase = nph;
      check_all($sformatf("rnd%0d", k), m_pc, m_adel(m_pc) ? 4'd4 : 4'd0,
                m_bd(m_phase, m_bd_prev, d_is_bj), im_rdata);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_pc.md
Name: if_fetch_pc

Overview:
- IF stage of the P7 five-stage MIPS pipeline: owns the PC register, computes next-PC from D-stage branch/jump decisions, and drives the instruction-memory address.
- Detects fetch-address exceptions (AdEL) and replaces the faulting instruction with a NOP.
- Produces Instr, pc_add4, ExcCode and BD for the IF/ID pipeline register directly downstream.
- Implements exception entry (jump to handler) and eret return (jump to EPC).

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  1  CP0 exception/interrupt request; redirect to HANDLER_PC.
- eret  in  1  eret decoded in D; redirect to epc.
- epc  in  32  EPC from CP0, forwarded value.
- stall  in  1  hazard stall; hold PC.
- npc_sel  in  2  0=PC+4, 1=branch taken, 2=j/jal, 3=jr/jalr (D-stage decision).
- d_pc  in  32  PC of the instruction in D.
- imm16  in  16  branch offset from D instruction.
- index26  in  26  j/jal target field.
- rs_val  in  32  forwarded GPR[rs] for jr/jalr.
- d_is_bj  in  1  D instruction is a branch/jump (the current fetch is a delay slot).
- im_rdata  in  32  instruction-memory read data for im_addr.
- im_addr  out  32  equal to pc; address presented to instruction memory.
- pc  out  32  current fetch PC.
- pc_add4  out  32  pc + 4.
- instr  out  32  fetched instruction, or 0 when AdEL.
- exc_code  out  4  5'd4 truncated to 4 bits (AdEL = 4) or 0.
- bd  out  1  delay-slot flag for the fetched instruction.

Behaviour:
- Single state register pc. Reset value is RESET_PC, so after reset im_addr = pc = 0x3000 and pc_add4 = 0x3004.
- The remaining outputs are combinational from pc and inputs; no extra latency. Im read is asynchronous within the cycle.
- Next-PC priority at posedge clk:
  - reset → RESET_PC.
  - else req → HANDLER_PC. This holds even if stall or eret is asserted.
  - else eret && !stall → epc.
  - else stall → hold pc.
  - else by npc_sel:
    - 0: pc+4.
    - 1: d_pc + 4 + (sign_extend(imm16) << 2).
    - 2: {d_pc[31:28], index26, 2'b00}; upper bits taken from d_pc+4.
    - 3: rs_val.
- All address arithmetic is 32-bit modulo 2^32. No overflow detection.
- Branch and jump targets are based on D-stage PC. The sequential fetch of the delay slot has already occurred, so no annulment is performed.
- AdEL: asserted when pc[1:0] != 0 or pc < IM_LO or pc > IM_HI. In that case exc_code = 4 and instr = 0; otherwise exc_code = 0 and instr = im_rdata.
- bd = d_is_bj, except:
  - bd = 0 for the first fetch after req or reset.
  - bd is held when the cycle is an eret return.
- A redirected jr target that is misaligned or out of range faults on the next cycle's fetch, not in D.
- Reset during a stall or req: reset wins. Reset during eret: eret is ignored.
- Simultaneous eret and stall: hold pc. eret takes effect on the first unstalled cycle.

Decomposition:
- Shared package cpu_defs:
  - NPC_PC4, NPC_BR, NPC_J, NPC_JR encodings.
  - EXC_ADEL = 4'd4, EXC_NONE = 4'd0.
  - RESET_PC, HANDLER_PC, IM_LO, IM_HI constants.
- One natural sub-module: npc_calc, a combinational target generator (pc+4 and the branch/j/jr targets selected by npc_sel). The PC register, priority logic and AdEL check stay in if_fetch_pc.

Test Plan:
- Reset high 2 cycles, then low → pc=0x3000, pc_add4=0x3004, bd=0; next cycles 0x3004, 0x3008.
- npc_sel=1, d_pc=0x3010, imm16=0xFFFE → next pc=0x300C. With imm16=0x0003 → 0x3020.
- npc_sel=3, rs_val=0x3002 → next pc=0x3002, exc_code=4, instr=0. rs_val=0x7000 → exc_code=4.
- stall=1 for 3 cycles with npc_sel=2 → pc held. Then req=1 with stall=1 → pc=0x4180, bd=0.
- eret=1, epc=0x3040 → pc=0x3040. eret=1 with stall=1 → held; stall drops → 0x3040.
- d_is_bj=1 with im_rdata=0x2409_0001 → bd=1, instr passes unchanged, exc_code=0.
